// File: rtl/pipe_hazard_ctl.sv
// Hazard sequencer for the 5-stage rv32 pipeline: stalls, flushes, bubbles and forwarding selects.
// Build option FWD_EN: defined -> execute-stage forwarding; undefined -> full interlock, no forwarding.
module pipe_hazard_ctl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic             de_use1,
    input  logic             de_use2,
    input  logic [4:0]       exe_rs1,
    input  logic [4:0]       exe_rs2,
    input  logic [4:0]       exe_rd,
    input  logic             exe_wen,
    input  logic             exe_load,
    input  logic             exe_br_taken,
    input  logic [4:0]       acc_rd,
    input  logic             acc_wen,
    input  logic [4:0]       wb_rd,
    input  logic             wb_wen,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             stall_de,
    output logic             stall_exe,
    output logic             stall_acc,
    output logic             flush_de,
    output logic             bubble_exe,
    output logic             bubble_wb,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic                mem_err_reg, mem_err_next;
    logic [CNT_W-1:0]    stall_cnt_reg, stall_cnt_next;

    logic                mem_pending;
    logic                timeout_hit;
    logic                mem_stall;
    logic                data_hazard;

    logic [1:0][4:0]     de_rs;
    logic [1:0]          de_use;
    logic [1:0]          hit_exe;
    logic [1:0][1:0]     fwd_sel;

    assign de_rs  = {de_rs2, de_rs1};
    assign de_use = {de_use2, de_use1};

`ifdef FWD_EN
    logic [1:0][4:0]     exe_rs;
    assign exe_rs = {exe_rs2, exe_rs1};
`else
    logic [1:0]          hit_acc;
    logic [1:0]          hit_wb;
    logic                unused_ok;
    assign unused_ok = ^{exe_rs1, exe_rs2, exe_load};
`endif

    // One lane per decode source operand; x0 never matches a producer.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign hit_exe[gi] = de_use[gi] & exe_wen & (exe_rd != 5'd0) & (de_rs[gi] == exe_rd);
`ifdef FWD_EN
        logic from_acc;
        logic from_wb;
        assign from_acc    = acc_wen & (acc_rd != 5'd0) & (exe_rs[gi] == acc_rd);
        assign from_wb     = wb_wen & (wb_rd != 5'd0) & (exe_rs[gi] == wb_rd);
        assign fwd_sel[gi] = from_acc ? 2'd1 : (from_wb ? 2'd2 : 2'd0);
`else
        assign hit_acc[gi] = de_use[gi] & acc_wen & (acc_rd != 5'd0) & (de_rs[gi] == acc_rd);
        assign hit_wb[gi]  = de_use[gi] & wb_wen & (wb_rd != 5'd0) & (de_rs[gi] == wb_rd);
        assign fwd_sel[gi] = 2'd0;
`endif
    end

`ifdef FWD_EN
    // With forwarding only a load result one instruction ahead is unavailable in time.
    assign data_hazard = exe_load & (|hit_exe);
`else
    assign data_hazard = (|hit_exe) | (|hit_acc) | (|hit_wb);
`endif

    assign mem_pending = mem_req & ~mem_ready;
    assign timeout_hit = (state_reg == ST_MEM_WAIT) & (wait_cnt_reg == WAIT_LAST);
    // On timeout the access is abandoned: the stall is released the same cycle.
    assign mem_stall   = mem_pending & ~timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= '0;
            mem_err_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            mem_err_reg   <= mem_err_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        mem_err_next   = mem_err_reg;
        stall_cnt_next = stall_cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (mem_pending) begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_pending) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else if (timeout_hit) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                    mem_err_next  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase
        if (stall_if && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        stall_if   = 1'b0;
        stall_de   = 1'b0;
        stall_exe  = 1'b0;
        stall_acc  = 1'b0;
        flush_de   = 1'b0;
        bubble_exe = 1'b0;
        bubble_wb  = 1'b0;
        fwd_a      = 2'd0;
        fwd_b      = 2'd0;
        if (rst) begin
            if (mem_stall) begin
                stall_if  = 1'b1;
                stall_de  = 1'b1;
                stall_exe = 1'b1;
                stall_acc = 1'b1;
                bubble_wb = 1'b1;
            end else if (state_reg == ST_RUN) begin
                // A taken branch discards the decode instr, so its load-use stall is moot.
                if (exe_br_taken) begin
                    flush_de   = 1'b1;
                    bubble_exe = 1'b1;
                end else if (data_hazard) begin
                    stall_if   = 1'b1;
                    stall_de   = 1'b1;
                    bubble_exe = 1'b1;
                end
                fwd_a = fwd_sel[0];
                fwd_b = fwd_sel[1];
            end
        end
    end

    assign mem_err   = mem_err_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a reference model of the hazard rules.
module tb_pipe_hazard_ctl;

    localparam int MT   = 16;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;
`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    de_rs1, de_rs2, exe_rs1, exe_rs2, exe_rd, acc_rd, wb_rd;
    logic          de_use1, de_use2, exe_wen, exe_load, exe_br_taken;
    logic          acc_wen, wb_wen, mem_req, mem_ready;
    logic          stall_if, stall_de, stall_exe, stall_acc, flush_de, bubble_exe, bubble_wb;
    logic [1:0]    fwd_a, fwd_b;
    logic          mem_err;
    logic [CW-1:0] stall_cnt;
    logic [10:0]   outs_vec;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    int m_streak;
    bit m_err;
    int m_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_use1(de_use1), .de_use2(de_use2),
        .exe_rs1(exe_rs1), .exe_rs2(exe_rs2), .exe_rd(exe_rd), .exe_wen(exe_wen),
        .exe_load(exe_load), .exe_br_taken(exe_br_taken),
        .acc_rd(acc_rd), .acc_wen(acc_wen), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_de(stall_de), .stall_exe(stall_exe), .stall_acc(stall_acc),
        .flush_de(flush_de), .bubble_exe(bubble_exe), .bubble_wb(bubble_wb),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    assign outs_vec = {stall_if, stall_de, stall_exe, stall_acc, flush_de, bubble_exe, bubble_wb,
                       fwd_a, fwd_b};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Does any used decode source read a register a pending producer has not yet written back?
    function automatic bit model_hazard();
        logic [4:0] prod_rd [3];
        bit         prod_ok [3];
        logic [4:0] src [2];
        bit         uses [2];
        prod_rd = '{exe_rd, acc_rd, wb_rd};
        if (FWD) prod_ok = '{exe_wen && exe_load, 1'b0, 1'b0};
        else     prod_ok = '{exe_wen, acc_wen, wb_wen};
        src  = '{de_rs1, de_rs2};
        uses = '{de_use1, de_use2};
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < 3; p++)
                if (uses[s] && prod_ok[p] && prod_rd[p] != 5'd0 && prod_rd[p] == src[s]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] r);
        if (!FWD) return 2'd0;
        if (acc_wen && acc_rd != 5'd0 && acc_rd == r) return 2'd1;
        if (wb_wen && wb_rd != 5'd0 && wb_rd == r) return 2'd2;
        return 2'd0;
    endfunction

    // m_streak = number of consecutive memory-stall cycles immediately before this one.
    function automatic logic [10:0] model_outs();
        logic sif, sde, sexe, sacc, fde, bexe, bwb;
        logic [1:0] fa, fb;
        {sif, sde, sexe, sacc, fde, bexe, bwb, fa, fb} = '0;
        if (rst) begin
            if (mem_req && !mem_ready && m_streak < MT) begin
                sif = 1'b1; sde = 1'b1; sexe = 1'b1; sacc = 1'b1; bwb = 1'b1;
            end else if (m_streak == 0) begin
                if (exe_br_taken) begin
                    fde = 1'b1; bexe = 1'b1;
                end else if (model_hazard()) begin
                    sif = 1'b1; sde = 1'b1; bexe = 1'b1;
                end
                fa = model_fwd(exe_rs1);
                fb = model_fwd(exe_rs2);
            end
        end
        return {sif, sde, sexe, sacc, fde, bexe, bwb, fa, fb};
    endfunction

    function automatic bit model_stall_if();
        logic [10:0] v;
        v = model_outs();
        return v[10];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_streak <= 0;
            m_err    <= 1'b0;
            m_cnt    <= 0;
        end else begin
            if (mem_req && !mem_ready) begin
                if (m_streak < MT) m_streak <= m_streak + 1;
                else begin
                    m_streak <= 0;
                    m_err    <= 1'b1;
                end
            end else begin
                m_streak <= 0;
            end
            if (model_stall_if() && m_cnt < CMAX) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("outs", 32'(outs_vec), 32'(model_outs()));
            chk("mem_err", 32'(mem_err), 32'(m_err));
            chk("stall_cnt", 32'(stall_cnt), m_cnt);
        end
    end

    task automatic clr();
        de_rs1 = 0; de_rs2 = 0; de_use1 = 0; de_use2 = 0;
        exe_rs1 = 0; exe_rs2 = 0; exe_rd = 0; exe_wen = 0; exe_load = 0; exe_br_taken = 0;
        acc_rd = 0; acc_wen = 0; wb_rd = 0; wb_wen = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit slow;
        clr();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check_en = 1'b1;

        @(negedge clk);
        chk("reset_outs", 32'(outs_vec), 0);
        chk("reset_stall_cnt", 32'(stall_cnt), 0);
        chk("reset_mem_err", 32'(mem_err), 0);
        tick();

        // Load-use, one stall cycle
        exe_load = 1; exe_wen = 1; exe_rd = 5; de_rs1 = 5; de_use1 = 1;
        @(negedge clk);
        chk("t2_stall_if", 32'(stall_if), 1);
        chk("t2_stall_de", 32'(stall_de), 1);
        chk("t2_bubble_exe", 32'(bubble_exe), 1);
        chk("t2_stall_exe", 32'(stall_exe), 0);
        tick();
        clr();
        @(negedge clk);
        chk("t2_stall_cnt", 32'(stall_cnt), 1);
        chk("t2_released", 32'(stall_if), 0);
        tick();

        // x0 never interlocks; forwarding priority
        exe_load = 1; exe_wen = 1; exe_rd = 0; de_rs1 = 0; de_use1 = 1;
        @(negedge clk);
        chk("t3_x0_no_stall", 32'(stall_if), 0);
        tick();
        clr();
        acc_rd = 7; wb_rd = 7; exe_rs2 = 7; acc_wen = 1; wb_wen = 1;
        @(negedge clk);
        chk("t3_fwd_b_acc", 32'(fwd_b), FWD ? 1 : 0);
        tick();
        acc_wen = 0;
        @(negedge clk);
        chk("t3_fwd_b_wb", 32'(fwd_b), FWD ? 2 : 0);
        tick();
        clr();

        // Branch beats load-use
        exe_br_taken = 1; exe_load = 1; exe_wen = 1; exe_rd = 9; de_rs2 = 9; de_use2 = 1;
        @(negedge clk);
        chk("t4_flush_de", 32'(flush_de), 1);
        chk("t4_bubble_exe", 32'(bubble_exe), 1);
        chk("t4_stall_if", 32'(stall_if), 0);
        tick();
        clr();

        // Three-cycle memory wait
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_stall_acc", 32'(stall_acc), 1);
            chk("t5_bubble_wb", 32'(bubble_wb), 1);
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        chk("t5_ready_no_stall", 32'(stall_if), 0);
        chk("t5_stall_cnt", 32'(stall_cnt), 4);
        tick();
        clr();
        @(negedge clk);
        chk("t5_mem_err", 32'(mem_err), 0);
        tick();

        // Reset in the middle of a memory wait
        mem_req = 1; mem_ready = 0;
        repeat (6) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t1_outs", 32'(outs_vec), 0);
        chk("t1_stall_cnt", 32'(stall_cnt), 0);
        chk("t1_mem_err", 32'(mem_err), 0);
        tick();
        clr();
        rst = 1'b1;
        @(negedge clk);
        chk("t1_run_after", 32'(stall_if), 0);
        tick();

        // Interlock until producer leaves writeback
        n = 0;
        acc_wen = 1; acc_rd = 3; de_rs2 = 3; de_use2 = 1;
        @(negedge clk);
        if (stall_if) n++;
        tick();
        acc_wen = 0; wb_wen = 1; wb_rd = 3;
        @(negedge clk);
        if (stall_if) n++;
        tick();
        wb_wen = 0;
        @(negedge clk);
        if (stall_if) n++;
        chk("t7_stall_len", n, FWD ? 0 : 2);
        chk("t7_stall_cnt", 32'(stall_cnt), FWD ? 0 : 2);
        tick();
        clr();

        // Memory that never answers
        mem_req = 1; mem_ready = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall_if) break;
            n++;
            tick();
        end
        chk("t6_stall_len", n, MT);
        tick();
        @(negedge clk);
        chk("t6_mem_err_set", 32'(mem_err), 1);
        clr();
        repeat (3) tick();
        @(negedge clk);
        chk("t6_mem_err_sticky", 32'(mem_err), 1);
        tick();

        // Counter saturation
        mem_req = 1; mem_ready = 0;
        repeat (320) tick();
        @(negedge clk);
        chk("sat_stall_cnt", 32'(stall_cnt), CMAX);
        tick();
        clr();
        tick();

        // Random traffic against the model
        slow = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) slow = ($urandom_range(0, 3) == 0);
            de_rs1       = 5'($urandom_range(0, 3));
            de_rs2       = 5'($urandom_range(0, 3));
            de_use1      = 1'($urandom_range(0, 1));
            de_use2      = 1'($urandom_range(0, 1));
            exe_rs1      = 5'($urandom_range(0, 3));
            exe_rs2      = 5'($urandom_range(0, 3));
            exe_rd       = 5'($urandom_range(0, 3));
            exe_wen      = 1'($urandom_range(0, 1));
            exe_load     = 1'($urandom_range(0, 1));
            exe_br_taken = ($urandom_range(0, 5) == 0);
            acc_rd       = 5'($urandom_range(0, 3));
            acc_wen      = 1'($urandom_range(0, 1));
            wb_rd        = 5'($urandom_range(0, 3));
            wb_wen       = 1'($urandom_range(0, 1));
            mem_req      = slow || ($urandom_range(0, 2) == 0);
            mem_ready    = slow ? 1'b0 : ($urandom_range(0, 2) != 0);
            rst          = ($urandom_range(0, 299) != 0);
            tick();
        end

        clr();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
